// File: rtl/lsu_mem_ctrl.sv
// Load/store unit memory controller.
//
// Accepts one load or store request from EX, checks its alignment, and issues
// one word-wide memory request with byte-lane masks. For loads it extracts and
// extends the addressed bytes from the returned word. It then presents one
// result to WB. A WAIT-state watchdog turns a missing memory response into a
// timeout fault.
//
// Ports:
//   clk, rst_n                   clock, asynchronous active-low reset
//   in_valid/in_ready            request handshake from EX
//   in_addr, in_wen, in_size,    byte address, store flag, size (0=B,1=H,2=W,3=D),
//   in_signed, in_wdata          sign-extend flag, right-aligned store data
//   out_valid/out_ready          result handshake to WB
//   out_rdata, out_err           extended load data, error (00 ok, 01 misaligned, 10 timeout)
//   mem_req_valid/mem_req_ready  memory request handshake
//   mem_addr, mem_wen,           word-aligned address, write flag,
//   mem_wdata, mem_wmask         lane-shifted store data, byte-lane mask
//   mem_resp_valid,              memory response (read data or write ack)
//   mem_resp_rdata               raw read word
module lsu_mem_ctrl #(
  parameter int unsigned DATA_W  = 64,
  parameter int unsigned ADDR_W  = 64,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [ADDR_W-1:0]   in_addr,
  input  logic                in_wen,
  input  logic [1:0]          in_size,
  input  logic                in_signed,
  input  logic [DATA_W-1:0]   in_wdata,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [DATA_W-1:0]   out_rdata,
  output logic [1:0]          out_err,
  output logic                mem_req_valid,
  input  logic                mem_req_ready,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic                mem_wen,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_wmask,
  input  logic                mem_resp_valid,
  input  logic [DATA_W-1:0]   mem_resp_rdata
);

  localparam int unsigned NB    = DATA_W / 8;
  localparam int unsigned OFF_W = $clog2(NB);
  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

  // Last WAIT cycle index: the counter reaches TIMEOUT at the end of this cycle.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  localparam logic [1:0] ERR_OK  = 2'b00;
  localparam logic [1:0] ERR_MIS = 2'b01;
  localparam logic [1:0] ERR_TO  = 2'b10;

  typedef enum logic [1:0] {StIdle, StReq, StWait, StResp} state_e;

  state_e             state_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [OFF_W-1:0]   off_q;
  logic [1:0]         size_q;
  logic               signed_q;
  logic               wen_q;

  // Request decode, evaluated on the incoming request
  logic               misaligned;
  logic [OFF_W-1:0]   in_off;
  logic [NB-1:0]      in_base_mask;
  logic [NB-1:0]      in_mask;
  logic [DATA_W-1:0]  in_wdata_sh;
  logic [ADDR_W-1:0]  in_addr_al;

  always_comb begin
    in_off = in_addr[OFF_W-1:0];
    case (in_size)
      2'd0:    misaligned = 1'b0;
      2'd1:    misaligned = in_addr[0];
      2'd2:    misaligned = |in_addr[1:0];
      default: misaligned = (|in_addr[2:0]) || (DATA_W == 32);
    endcase
    case (in_size)
      2'd0:    in_base_mask = NB'(8'h01);
      2'd1:    in_base_mask = NB'(8'h03);
      2'd2:    in_base_mask = NB'(8'h0F);
      default: in_base_mask = NB'(8'hFF);
    endcase
    in_mask               = in_base_mask << in_off;
    in_wdata_sh           = in_wdata << {in_off, 3'b000};
    in_addr_al            = in_addr;
    in_addr_al[OFF_W-1:0] = '0;
  end

  // Load data extraction from the raw response word
  logic [DATA_W-1:0]  rd_sh;
  logic [DATA_W-1:0]  rd_mask;
  logic [DATA_W-1:0]  rd_ext;
  logic               rd_sign;

  always_comb begin
    rd_sh = mem_resp_rdata >> {off_q, 3'b000};
    case (size_q)
      2'd0: begin
        rd_mask = DATA_W'(8'hFF);
        rd_sign = rd_sh[7];
      end
      2'd1: begin
        rd_mask = DATA_W'(16'hFFFF);
        rd_sign = rd_sh[15];
      end
      2'd2: begin
        rd_mask = DATA_W'(32'hFFFF_FFFF);
        rd_sign = rd_sh[31];
      end
      default: begin
        rd_mask = '1;
        rd_sign = rd_sh[DATA_W-1];
      end
    endcase
    rd_ext = rd_sh & rd_mask;
    if (signed_q && rd_sign) begin
      rd_ext = rd_ext | ~rd_mask;
    end
  end

  assign in_ready      = (state_q == StIdle);
  assign mem_req_valid = (state_q == StReq);
  assign out_valid     = (state_q == StResp);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      off_q     <= '0;
      size_q    <= '0;
      signed_q  <= 1'b0;
      wen_q     <= 1'b0;
      out_rdata <= '0;
      out_err   <= ERR_OK;
      mem_addr  <= '0;
      mem_wen   <= 1'b0;
      mem_wdata <= '0;
      mem_wmask <= '0;
    end else begin
      case (state_q)
        StIdle: begin
          if (in_valid) begin
            off_q     <= in_off;
            size_q    <= in_size;
            signed_q  <= in_signed;
            wen_q     <= in_wen;
            out_rdata <= '0;
            if (misaligned) begin
              // Fault straight to the result; the memory port stays untouched.
              out_err <= ERR_MIS;
              state_q <= StResp;
            end else begin
              out_err   <= ERR_OK;
              mem_addr  <= in_addr_al;
              mem_wen   <= in_wen;
              mem_wdata <= in_wdata_sh;
              mem_wmask <= in_mask;
              state_q   <= StReq;
            end
          end
        end
        StReq: begin
          if (mem_req_ready) begin
            cnt_q   <= '0;
            state_q <= StWait;
          end
        end
        StWait: begin
          cnt_q <= cnt_q + 1'b1;
          // A response in the final cycle still beats the timeout.
          if (mem_resp_valid) begin
            out_err   <= ERR_OK;
            out_rdata <= wen_q ? '0 : rd_ext;
            state_q   <= StResp;
          end else if (cnt_q == CNT_LAST) begin
            out_err   <= ERR_TO;
            out_rdata <= '0;
            state_q   <= StResp;
          end
        end
        StResp: begin
          if (out_ready) begin
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Self-checking bench for lsu_mem_ctrl (DATA_W=64, ADDR_W=64, TIMEOUT=4).
// Directed scenarios plus randomized transactions, checked against a
// byte-level reference model.
module tb_lsu_mem_ctrl;

  localparam int T_O = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [63:0] in_addr = '0;
  logic        in_wen = 1'b0;
  logic [1:0]  in_size = '0;
  logic        in_signed = 1'b0;
  logic [63:0] in_wdata = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [63:0] out_rdata;
  logic [1:0]  out_err;
  logic        mem_req_valid;
  logic        mem_req_ready = 1'b0;
  logic [63:0] mem_addr;
  logic        mem_wen;
  logic [63:0] mem_wdata;
  logic [7:0]  mem_wmask;
  logic        mem_resp_valid = 1'b0;
  logic [63:0] mem_resp_rdata = '0;

  int errors = 0;
  int checks = 0;
  int n_mem_req = 0;

  lsu_mem_ctrl #(
    .DATA_W (64),
    .ADDR_W (64),
    .TIMEOUT(T_O)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_addr       (in_addr),
    .in_wen        (in_wen),
    .in_size       (in_size),
    .in_signed     (in_signed),
    .in_wdata      (in_wdata),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_rdata     (out_rdata),
    .out_err       (out_err),
    .mem_req_valid (mem_req_valid),
    .mem_req_ready (mem_req_ready),
    .mem_addr      (mem_addr),
    .mem_wen       (mem_wen),
    .mem_wdata     (mem_wdata),
    .mem_wmask     (mem_wmask),
    .mem_resp_valid(mem_resp_valid),
    .mem_resp_rdata(mem_resp_rdata)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rst_n && mem_req_valid && mem_req_ready) n_mem_req <= n_mem_req + 1;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, want completion");
    $fatal(1);
  end

  // Reference model: pick bytes off..off+nb-1 out of the word, then extend.
  function automatic logic [63:0] load_model(logic [63:0] word, int off, int nb, bit sgn);
    logic [63:0] v = '0;
    for (int i = 0; i < nb; i++) v[8*i +: 8] = word[8*(off+i) +: 8];
    if (sgn && v[8*nb-1]) begin
      for (int i = nb; i < 8; i++) v[8*i +: 8] = 8'hFF;
    end
    return v;
  endfunction

  function automatic logic [7:0] mask_model(int off, int nb);
    logic [7:0] m = '0;
    for (int i = 0; i < nb; i++) if (off + i < 8) m[off+i] = 1'b1;
    return m;
  endfunction

  // One full transaction with configurable handshake stalls.
  // resp_lat >= T_O means memory never answers in time.
  task automatic run_txn(input string name, input logic [63:0] addr, input bit wen,
                         input logic [1:0] size, input bit sgn, input logic [63:0] wdata,
                         input logic [63:0] rword, input int req_lat, input int resp_lat,
                         input int out_lat);
    int off, nb, nreq0;
    bit mis, got_resp;
    logic [63:0] exp_rd, exp_wd;
    logic [7:0]  exp_mask;
    logic [1:0]  exp_err;
    off      = int'(addr % 8);
    nb       = 1 << size;
    mis      = (addr % nb) != 0;
    exp_mask = mask_model(off, nb);
    exp_wd   = wdata << (8 * off);
    nreq0    = n_mem_req;
    got_resp = 0;

    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL %s idle_ready: got %b want 1", name, in_ready);
    end
    in_valid = 1'b1; in_addr = addr; in_wen = wen; in_size = size;
    in_signed = sgn; in_wdata = wdata;
    @(posedge clk); #1;
    in_valid = 1'b0; in_wdata = {$urandom, $urandom};

    if (mis) begin
      exp_err = 2'b01;
      exp_rd  = '0;
    end else begin
      for (int c = 0; c <= req_lat; c++) begin
        checks++;
        if (mem_req_valid !== 1'b1 || mem_addr !== (addr & ~64'h7) || mem_wen !== wen ||
            mem_wdata !== exp_wd || mem_wmask !== exp_mask) begin
          errors++;
          $display("FAIL %s req[%0d]: got v=%b a=%h w=%b d=%h m=%h want v=1 a=%h w=%b d=%h m=%h",
                   name, c, mem_req_valid, mem_addr, mem_wen, mem_wdata, mem_wmask,
                   addr & ~64'h7, wen, exp_wd, exp_mask);
        end
        if (c == req_lat) mem_req_ready = 1'b1;
        @(posedge clk); #1;
        mem_req_ready = 1'b0;
      end
      for (int k = 0; k < T_O && !got_resp; k++) begin
        checks++;
        if (out_valid !== 1'b0 || mem_req_valid !== 1'b0 || in_ready !== 1'b0) begin
          errors++;
          $display("FAIL %s wait[%0d]: got ov=%b rv=%b ir=%b want 0 0 0",
                   name, k, out_valid, mem_req_valid, in_ready);
        end
        if (k == resp_lat) begin
          mem_resp_valid = 1'b1;
          mem_resp_rdata = rword;
          got_resp = 1;
        end
        @(posedge clk); #1;
        mem_resp_valid = 1'b0;
        mem_resp_rdata = {$urandom, $urandom};
      end
      exp_err = got_resp ? 2'b00 : 2'b10;
      exp_rd  = (got_resp && !wen) ? load_model(rword, off, nb, sgn) : 64'h0;
    end

    for (int c = 0; c <= out_lat; c++) begin
      checks++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || mem_req_valid !== 1'b0 ||
          out_err !== exp_err || out_rdata !== exp_rd) begin
        errors++;
        $display("FAIL %s resp[%0d]: got ov=%b ir=%b rv=%b err=%b rd=%h want 1 0 0 err=%b rd=%h",
                 name, c, out_valid, in_ready, mem_req_valid, out_err, out_rdata, exp_err, exp_rd);
      end
      if (c == out_lat) begin
        out_ready = 1'b1;
      end else begin
        // Stray response while holding the result must not disturb it.
        mem_resp_valid = 1'b1;
        mem_resp_rdata = ~rword;
      end
      @(posedge clk); #1;
      out_ready = 1'b0;
      mem_resp_valid = 1'b0;
    end

    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL %s done: got ov=%b ir=%b want 0 1", name, out_valid, in_ready);
    end
    checks++;
    if (n_mem_req - nreq0 !== (mis ? 0 : 1)) begin
      errors++;
      $display("FAIL %s mem_txn_count: got %0d want %0d", name, n_mem_req - nreq0, mis ? 0 : 1);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    checks++;
    if (out_valid !== 1'b0 || mem_req_valid !== 1'b0 || out_rdata !== 64'h0 ||
        out_err !== 2'b00 || mem_wmask !== 8'h0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_state: got ov=%b rv=%b rd=%h err=%b m=%h ir=%b want 0 0 0 00 00 1",
               out_valid, mem_req_valid, out_rdata, out_err, mem_wmask, in_ready);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_release_ready: got %b want 1", in_ready);
    end
  endtask

  task automatic test_directed();
    run_txn("ld_b_signed", 64'h8000_0003, 0, 2'd0, 1, 64'h0, 64'h0000_0000_8000_0000, 0, 0, 0);
    run_txn("st_h", 64'h8000_0006, 1, 2'd1, 0, 64'hBEEF, 64'h0, 0, 0, 0);
    run_txn("ld_w_misaligned", 64'h8000_0002, 0, 2'd2, 0, 64'h0, 64'h0, 0, 0, 1);
    run_txn("ld_d_unsigned", 64'h8000_0010, 0, 2'd3, 0, 64'h0, 64'hFEDC_BA98_7654_3210, 0, 1, 0);
    run_txn("ld_h_zext", 64'h8000_0002, 0, 2'd1, 0, 64'h0, 64'h0000_0000_F00D_0000, 0, 2, 0);
  endtask

  task automatic test_timeout();
    run_txn("timeout", 64'h8000_0008, 0, 2'd2, 1, 64'h0, 64'hFFFF_FFFF_FFFF_FFFF, 0, T_O, 1);
    run_txn("resp_wins_last", 64'h8000_000C, 0, 2'd2, 1, 64'h0, 64'h8765_4321_0000_0000,
            0, T_O - 1, 0);
    run_txn("st_timeout", 64'h8000_0001, 1, 2'd0, 0, 64'h5A, 64'h0, 1, T_O, 0);
  endtask

  task automatic test_stalls();
    run_txn("stall_ld", 64'h8000_0004, 0, 2'd2, 0, 64'h0, 64'h1234_5678_9ABC_DEF0, 3, 1, 2);
    run_txn("stall_st", 64'h8000_0003, 1, 2'd0, 0, 64'hFFFF_FFFF_FFFF_FFA5, 64'h0, 3, 0, 2);
  endtask

  task automatic test_reset_in_wait();
    int nreq0;
    in_valid = 1'b1; in_addr = 64'h8000_0020; in_wen = 1'b0; in_size = 2'd3; in_signed = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    mem_req_ready = 1'b1;
    @(posedge clk); #1;
    mem_req_ready = 1'b0;
    nreq0 = n_mem_req;
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || mem_req_valid !== 1'b0 || in_ready !== 1'b1 ||
        out_rdata !== 64'h0 || out_err !== 2'b00 || mem_wmask !== 8'h0) begin
      errors++;
      $display("FAIL rst_in_wait_async: got ov=%b rv=%b ir=%b rd=%h err=%b m=%h want 0 0 1 0 00 00",
               out_valid, mem_req_valid, in_ready, out_rdata, out_err, mem_wmask);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL rst_in_wait_ready: got %b want 1", in_ready);
    end
    mem_resp_valid = 1'b1;
    mem_resp_rdata = 64'hDEAD_BEEF_DEAD_BEEF;
    @(posedge clk); #1;
    mem_resp_valid = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || n_mem_req !== nreq0) begin
      errors++;
      $display("FAIL rst_stray_resp: got ov=%b ir=%b req=%0d want 0 1 %0d",
               out_valid, in_ready, n_mem_req, nreq0);
    end
  endtask

  task automatic test_back_to_back();
    int accepts = 0;
    int results = 0;
    logic [63:0] w;
    w = {$urandom, $urandom};
    mem_req_ready = 1'b1; mem_resp_valid = 1'b1; mem_resp_rdata = w; out_ready = 1'b1;
    in_valid = 1'b1; in_addr = 64'h1000; in_wen = 1'b0; in_size = 2'd3; in_signed = 1'b0;
    for (int c = 0; c < 12; c++) begin
      if (in_valid && in_ready) accepts++;
      if (out_valid) begin
        results++;
        checks++;
        if (out_rdata !== w || out_err !== 2'b00) begin
          errors++;
          $display("FAIL b2b_data[%0d]: got rd=%h err=%b want rd=%h err=00", c, out_rdata, out_err, w);
        end
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0; mem_req_ready = 1'b0; mem_resp_valid = 1'b0; out_ready = 1'b0;
    checks++;
    if (accepts !== 3 || results !== 3) begin
      errors++;
      $display("FAIL b2b_rate: got accepts=%0d results=%0d want 3 3", accepts, results);
    end
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL b2b_idle: got %b want 1", in_ready);
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 40; n++) begin
      run_txn("random", {$urandom, $urandom}, 1'($urandom_range(0, 1)),
              2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), {$urandom, $urandom},
              {$urandom, $urandom}, $urandom_range(0, 3), $urandom_range(0, T_O + 1),
              $urandom_range(0, 2));
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_timeout();
    test_stalls();
    test_reset_in_wait();
    test_back_to_back();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
